dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-requester controller that shares the single word-addressed data memory between the core load/store path (port 0) and a secondary master such as a DMA or debug loader (port 1).
- Grants one transaction at a time using round-robin arbitration.
- Sequences each access through a small FSM.
- Adds byte-enable stores by read-modify-write on the word memory.
- Sits between the masters and the data memory instance. Drives the memory's we/a/wd inputs and samples its asynchronous rd output.

Parameters:
DW, 32, data width in bits (fixed at 32; byte enables assume 4 bytes)
AW, 32, address width in bits

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  port 0 request; held until m0_gnt
m0_we  in  1  port 0: 1=write, 0=read
m0_addr  in  AW  port 0 byte address; bits [1:0] ignored
m0_wdata  in  DW  port 0 write data
m0_be  in  4  port 0 byte enables; bit i covers wdata[8i+7:8i]
m0_gnt  out  1  port 0 accepted this cycle
m0_done  out  1  one-cycle pulse when the port 0 transaction completes
m0_rdata  out  DW  port 0 read data, valid with m0_done on reads
m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_done, m1_rdata: identical meaning for port 1
mem_we  out  1  memory write enable
mem_a  out  AW  memory address, always {addr[AW-1:2],2'b00}
mem_wd  out  DW  memory write data
mem_rd  in  DW  memory read data, combinational from mem_a

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; rr_last=1, so port 0 wins the first contention.
  - All gnt/done=0; m0_rdata=m1_rdata=0; mem_we=0; mem_a=0; mem_wd=0.
  - Captured request registers are cleared.
- States:
  - IDLE: mx_gnt is combinational from req and state.
    - Winner: the only requester; if both request, the one not equal to rr_last.
    - On gnt, latch id/we/addr/wdata/be and set rr_last=winner.
    - Next state:
      - Read or partial write (be!=4'hF): go to READ.
      - Full write (be==4'hF): go to WRITE.
      - Write with be==4'h0: go straight to RESP; no memory access.
  - READ: mem_a=latched addr; buf<=mem_rd.
    - Read transaction: go to RESP.
    - Partial write: go to WRITE.
  - WRITE: mem_we=1; mem_a=latched addr.
    - mem_wd byte i = be[i] ? wdata byte i : buf byte i.
    - Full write uses wdata directly.
    - Go to RESP.
  - RESP: pulse done for the latched id.
    - On reads, load that port's rdata from buf.
    - Go to IDLE.
- Latency, counted from the gnt cycle T:
  - Read: done at T+2.
  - Full write: mem_we at T+1, done at T+2.
  - Partial write: read at T+1, mem_we at T+2, done at T+3.
  - be=0 write: done at T+1.
- Grants:
  - At most one gnt asserted per cycle.
  - No gnt outside IDLE; requests are held off until RESP returns to IDLE.
  - Back-to-back requests are granted in the IDLE cycle after RESP.
- Request hold and withdrawal:
  - A master may deassert req before gnt; it is never granted.
  - Inputs after gnt are ignored (latched copies used).
- mx_rdata holds its value until the next read completion on the same port; writes do not change it.
- mem_we is high only in WRITE. mem_a holds the latched address in READ/WRITE and 0 in IDLE/RESP.
- Reset mid-transaction:
  - Abort immediately; no mem_we or done in following cycles.
  - A write that already reached WRITE in the reset cycle is not guaranteed.
- Address bits [1:0] have no effect on mem_a; sub-word selection is by be only.

Test Plan:
- Single port-0 read, mem[0x10]=0xDEADBEEF, m0 read addr 0x10 -> m0_gnt at T, m0_done at T+2, m0_rdata=0xDEADBEEF, mem_we never 1.
- Partial write: mem[0x20]=0x11223344, m1 write addr 0x22, be=4'b0100, wdata=0xAABBCCDD -> mem_we only at T+2 with mem_wd=0x11BB3344, m1_done at T+3.
- Contention: both req from reset, held -> m0 granted first, m1 granted in the IDLE cycle after m0_done; a repeated m0 request then loses to a fresh m1 request (alternation over 4 transactions).
- Full write then read back: m0 write 0x30 be=F 0xCAFEF00D -> mem_we at T+1, done at T+2; follow-up read returns 0xCAFEF00D; m1_rdata unchanged.
- Reset asserted in READ of a partial write -> next cycle state IDLE, no mem_we, no done; memory word unchanged.
- Withdrawn request: m1_req high for one cycle while m0 is being served, then low -> m1_gnt never asserted; be=0 write completes with done at T+1 and no mem_we.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin two-master front end for a word-addressed data memory; byte-enable stores via read-modify-write.
// Latency from grant: read 2, full write 2, partial write 3, empty-mask write 1; requests wait in IDLE until granted.
module dmem_arbiter #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_be,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_be,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t        state, state_nxt;
    logic          rr_last;
    logic          cap_id;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic [3:0]    cap_be;
    logic [DW-1:0] buf_q;

    logic          grant;
    logic          win;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [3:0]    sel_be;
    logic [DW-1:0] merged;

    always_comb begin
        win       = (m0_req && m1_req) ? ~rr_last : m1_req;
        grant     = (state == IDLE) && !reset && (m0_req || m1_req);
        m0_gnt    = grant && !win;
        m1_gnt    = grant && win;
        sel_we    = win ? m1_we    : m0_we;
        sel_addr  = win ? m1_addr  : m0_addr;
        sel_wdata = win ? m1_wdata : m0_wdata;
        sel_be    = win ? m1_be    : m0_be;
    end

    // With be=4'hF the merge yields wdata unchanged, so full writes share this path.
    always_comb begin
        merged = buf_q;
        for (int i = 0; i < 4; i++) begin
            if (cap_be[i]) merged[8*i +: 8] = cap_wdata[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        m0_done   = 1'b0;
        m1_done   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    if (!sel_we)               state_nxt = READ;
                    else if (sel_be == 4'hF)   state_nxt = WRITE;
                    else if (sel_be == 4'h0)   state_nxt = RESP;
                    else                       state_nxt = READ;
                end
            end
            READ: begin
                mem_a     = cap_addr & ~AW'(3);
                state_nxt = cap_we ? WRITE : RESP;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_a     = cap_addr & ~AW'(3);
                mem_wd    = merged;
                state_nxt = RESP;
            end
            RESP: begin
                m0_done   = !cap_id;
                m1_done   = cap_id;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            cap_id    <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            buf_q     <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                rr_last   <= win;
                cap_id    <= win;
                cap_we    <= sel_we;
                cap_addr  <= sel_addr;
                cap_wdata <= sel_wdata;
                cap_be    <= sel_be;
            end
            // Read data is loaded on the READ edge so it is already valid while done pulses in RESP.
            if (state == READ) begin
                buf_q <= mem_rd;
                if (!cap_we) begin
                    if (cap_id) m1_rdata <= mem_rd;
                    else        m0_rdata <= mem_rd;
                end
            end
        end
    end

endmodule
